e_mdu: RTL and testbench

Execute-stage multiply/divide unit for the pipelined MIPS core, sitting beside the E-stage ALU and owning the HI/LO register pair. It performs `mult`, `multu`, `div` and `divu` with fixed, parametrised latencies, and handles the `mthi`/`mtlo` writes and `mfhi`/`mflo` reads. It drives a `Busy` flag that the hazard unit uses to stall dependent MDU instructions.

---
 rtl/e_mdu_pkg.sv | 31 +++
 rtl/e_mdu.sv | 143 ++++++++++++++
 tb/tb_e_mdu.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: op encodings (4 bits to match ALUOp), default latencies
// and the controller state type.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // True for the ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_md(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO. Results are computed at launch into
// pending registers and committed after a fixed, parametrised latency.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       MDUOp,
  input  logic             Start,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] Out
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] phi_q, phi_d;
  logic [WIDTH-1:0] plo_q, plo_d;

  logic             idle;
  logic             launch;
  logic             is_mul;

  logic             sgn_mul;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;

  logic             sgn_div, a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0] mag_a, mag_b, mag_b_safe;
  logic [WIDTH-1:0] quo_u, rem_u, quo, rem;

  assign idle   = (state_q == ST_IDLE);
  assign launch = Start & is_md(MDUOp) & idle;
  assign is_mul = (MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU);

  // Sign-extending to 2*WIDTH lets one unsigned multiplier serve mult and multu.
  assign sgn_mul = (MDUOp == MDU_MULT);
  assign ext_a   = {{WIDTH{sgn_mul & A[WIDTH-1]}}, A};
  assign ext_b   = {{WIDTH{sgn_mul & B[WIDTH-1]}}, B};
  assign prod    = ext_a * ext_b;

  assign sgn_div    = (MDUOp == MDU_DIV);
  assign a_neg      = sgn_div & A[WIDTH-1];
  assign b_neg      = sgn_div & B[WIDTH-1];
  assign mag_a      = a_neg ? ('0 - A) : A;
  assign mag_b      = b_neg ? ('0 - B) : B;
  assign div_zero   = (B == '0);
  assign mag_b_safe = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
  assign div_ovf    = sgn_div & (A == MIN_NEG) & (B == '1);

  always_comb begin
    quo_u = mag_a / mag_b_safe;
    rem_u = mag_a % mag_b_safe;
    quo   = (a_neg ^ b_neg) ? ('0 - quo_u) : quo_u;
    rem   = a_neg ? ('0 - rem_u) : rem_u;
    if (div_ovf) begin
      quo = MIN_NEG;
      rem = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_RUN;
          cnt_d   = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          if (is_mul) begin
            {phi_d, plo_d} = prod;
          end else if (div_zero) begin
            // Pending copies current HI/LO so the commit leaves them untouched.
            phi_d = hi_q;
            plo_d = lo_q;
          end else begin
            phi_d = rem;
            plo_d = quo;
          end
        end else if (Start && MDUOp == MDU_MTHI) begin
          hi_d = A;
        end else if (Start && MDUOp == MDU_MTLO) begin
          lo_d = A;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          hi_d    = phi_q;
          lo_d    = plo_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign Busy = (state_q == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    Out = '0;
    if (MDUOp == MDU_MFHI) Out = hi_q;
    else if (MDUOp == MDU_MFLO) Out = lo_q;
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed cases plus randomized traffic against a
// cycle-level arithmetic model of HI/LO and the busy window.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO, Out;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  int          m_left;
  bit          m_pend;

  e_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp), .Start(Start),
    .Busy(Busy), .HI(HI), .LO(LO), .Out(Out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_out(input logic [3:0] op);
    if (op == MDU_MFHI) return m_hi;
    if (op == MDU_MFLO) return m_lo;
    return 32'h0;
  endfunction

  task automatic model_launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [63:0] p;
    sa = a;
    sb = b;
    m_pend = 1'b1;
    case (op)
      MDU_MULT: begin
        p = longint'(sa) * longint'(sb);
        m_phi = p[63:32]; m_plo = p[31:0]; m_left = 5;
      end
      MDU_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        m_phi = p[63:32]; m_plo = p[31:0]; m_left = 5;
      end
      MDU_DIV: begin
        m_left = 10;
        if (b == 0) m_pend = 1'b0;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_plo = 32'h8000_0000; m_phi = 32'h0;
        end else begin
          m_plo = sa / sb; m_phi = sa % sb;
        end
      end
      default: begin
        m_left = 10;
        if (b == 0) m_pend = 1'b0;
        else begin
          m_plo = a / b; m_phi = a % b;
        end
      end
    endcase
  endtask

  task automatic model_edge(input logic [3:0] op, input logic st, input logic [31:0] a, input logic [31:0] b);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pend) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (st) begin
      if (is_md(op)) model_launch(op, a, b);
      else if (op == MDU_MTHI) m_hi = a;
      else if (op == MDU_MTLO) m_lo = a;
    end
  endtask

  task automatic step(input logic [3:0] op, input logic st, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MDUOp = op; Start = st; A = a; B = b;
    #1;
    chk("out", Out, model_out(op));
    @(posedge clk);
    model_edge(op, st, a, b);
    #1;
    chk("busy", {31'h0, Busy}, {31'h0, (m_left > 0)});
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(MDU_NONE, 1'b0, $urandom, $urandom);
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_left = 0; m_pend = 0;
    reset = 1'b1; Start = 1'b0; MDUOp = MDU_MFHI; A = 0; B = 0;
    #2;
    chk("rst_busy", {31'h0, Busy}, 32'h0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_out", Out, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // mult -2 * 3
    step(MDU_MULT, 1'b1, 32'hFFFF_FFFE, 32'd3);
    idle(5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    // multu 0xFFFFFFFF * 2, then mfhi
    step(MDU_MULTU, 1'b1, 32'hFFFF_FFFF, 32'd2);
    idle(5);
    chk("multu_hi", HI, 32'h1);
    chk("multu_lo", LO, 32'hFFFF_FFFE);
    @(negedge clk); MDUOp = MDU_MFHI; Start = 1'b0; #1;
    chk("mfhi_out", Out, 32'h1);
    step(MDU_MFHI, 1'b1, 32'h0, 32'h0);

    // div -7 / 2, then divu by zero leaves HI/LO alone
    step(MDU_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
    idle(10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    step(MDU_DIVU, 1'b1, 32'd7, 32'd0);
    chk("dz_busy", {31'h0, Busy}, 32'h1);
    idle(10);
    chk("dz_hi", HI, 32'hFFFF_FFFF);
    chk("dz_lo", LO, 32'hFFFF_FFFD);

    // signed overflow
    step(MDU_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(10);
    chk("ovf_lo", LO, 32'h8000_0000);
    chk("ovf_hi", HI, 32'h0);

    // mthi/mtlo and reads; mtlo while busy is ignored
    step(MDU_MTLO, 1'b1, 32'h0, 32'h0);
    step(MDU_MTHI, 1'b1, 32'h1234, 32'h0);
    chk("mthi_hi", HI, 32'h1234);
    step(MDU_MFLO, 1'b1, 32'h0, 32'h0);
    step(MDU_MULT, 1'b1, 32'd3, 32'd4);
    step(MDU_MTLO, 1'b1, 32'hDEAD_BEEF, 32'h0);
    chk("ign_lo", LO, 32'h0);
    idle(4);
    chk("ign_commit_lo", LO, 32'd12);
    chk("ign_commit_hi", HI, 32'h0);

    // back-to-back launch in the first non-busy cycle, then mthi right after commit
    step(MDU_DIVU, 1'b1, 32'd100, 32'd7);
    step(MDU_MTHI, 1'b1, 32'h5555, 32'h0);
    idle(9);
    step(MDU_MTHI, 1'b1, 32'h7777, 32'h0);
    chk("b2b_hi", HI, 32'h7777);
    chk("b2b_lo", LO, 32'd14);

    // randomized traffic under hazard-unit rules (no Start while busy)
    for (int i = 0; i < 400; i++) begin
      if (m_left == 0 && ($urandom % 3) != 0)
        step(4'($urandom_range(1, 6)), 1'b1, rand_opnd(), rand_opnd());
      else
        step(4'($urandom_range(0, 8)), 1'b0, rand_opnd(), rand_opnd());
    end
    idle(11);

    // reset in the third busy cycle of a mult
    step(MDU_MTHI, 1'b1, 32'hAAAA_0001, 32'h0);
    step(MDU_MTLO, 1'b1, 32'h5555_0002, 32'h0);
    step(MDU_MULT, 1'b1, 32'd1000, 32'd1000);
    idle(2);
    @(negedge clk);
    MDUOp = MDU_MFLO; Start = 1'b0;
    reset = 1'b1;
    #1;
    m_hi = 0; m_lo = 0; m_left = 0; m_pend = 0;
    chk("mid_rst_busy", {31'h0, Busy}, 32'h0);
    chk("mid_rst_hi", HI, 32'h0);
    chk("mid_rst_lo", LO, 32'h0);
    chk("mid_rst_out", Out, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idle(8);
    chk("no_commit_lo", LO, 32'h0);
    chk("no_commit_hi", HI, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
